// File: rtl/fsm_assoc_data.sv
// ---------------------------------------------------------------------------
// fsm_assoc_data
//   Control FSM for the ASCON-128 associated-data phase. It is started by the
//   initialisation FSM and absorbs AD blocks one at a time. For each block the
//   block is XORed into state word x0 and a p6 permutation (rounds 6..11) runs.
//   On the last round of the last block, domain separation XORs 1 into the
//   state LSB. When there is no AD at all, the domain-separation XOR is still
//   applied in a single SEP cycle. end_o then hands control to the
//   plaintext-phase FSM.
//
// Ports
//   clock_i        rising-edge clock
//   reset_i        synchronous, active-high reset
//   start_i        pulse from the init FSM; only honoured in IDLE
//   no_ad_i        sampled with start_i: AD is empty, skip absorption
//   ad_valid_i     AD block present; only honoured in WAIT_AD
//   ad_last_i      sampled with an accepted ad_valid_i: last AD block
//   round_i        current value of the shared permutation round counter
//   ad_ready_o     FSM accepts an AD block this cycle
//   en_cpt_perm_o  round counter increment enable
//   init_p6_o      load round counter with 6
//   init_p12_o     load round counter with 0 (never used by this phase)
//   input_mode_o   0: permutation input is state ^ data, 1: loop state
//   en_reg_state_o state register write enable
//   en_xor_data_o  XOR AD block into x0
//   en_xor_lsb_o   XOR 1 into the state LSB (domain separation)
//   ad_count_o     AD blocks absorbed since start, saturating
//   end_o          one-cycle pulse, AD phase complete
// ---------------------------------------------------------------------------
module fsm_assoc_data #(
  parameter int CNT_W = 8
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             no_ad_i,
  input  logic             ad_valid_i,
  input  logic             ad_last_i,
  input  logic [3:0]       round_i,
  output logic             ad_ready_o,
  output logic             en_cpt_perm_o,
  output logic             init_p6_o,
  output logic             init_p12_o,
  output logic             input_mode_o,
  output logic             en_reg_state_o,
  output logic             en_xor_data_o,
  output logic             en_xor_lsb_o,
  output logic [CNT_W-1:0] ad_count_o,
  output logic             end_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_AD = 3'd1,
    S_CONF    = 3'd2,
    S_RD6     = 3'd3,
    S_RD7_10  = 3'd4,
    S_RD11    = 3'd5,
    S_SEP     = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  // Round 10 is the last round that still needs the counter to advance.
  // Round 11 is handled by RD11 with the counter idle.
  localparam logic [3:0]       LAST_LOOP_RND = 4'd10;
  localparam logic [CNT_W-1:0] CNT_MAX       = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic             last_q;
  logic [CNT_W-1:0] cnt_q;

  // State, last-block flag and block counter.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_WAIT_AD && ad_valid_i)
        last_q <= ad_last_i;
      // The count restarts with every AD phase. It advances once per
      // completed block, in RD11, and saturates instead of wrapping.
      if (state_q == S_IDLE && start_i)
        cnt_q <= '0;
      else if (state_q == S_RD11 && cnt_q != CNT_MAX)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  // Next-state logic and Moore outputs. en_xor_lsb_o in RD11 also depends
  // on the last-block flag.
  always_comb begin
    state_d        = state_q;
    ad_ready_o     = 1'b0;
    en_cpt_perm_o  = 1'b0;
    init_p6_o      = 1'b0;
    init_p12_o     = 1'b0;
    input_mode_o   = 1'b0;
    en_reg_state_o = 1'b0;
    en_xor_data_o  = 1'b0;
    en_xor_lsb_o   = 1'b0;
    end_o          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i)
          state_d = no_ad_i ? S_SEP : S_WAIT_AD;
      end
      S_WAIT_AD: begin
        ad_ready_o = 1'b1;
        if (ad_valid_i)
          state_d = S_CONF;
      end
      S_CONF: begin
        // Load the counter with 6. It then reads 6 in RD6.
        init_p6_o     = 1'b1;
        en_cpt_perm_o = 1'b1;
        state_d       = S_RD6;
      end
      S_RD6: begin
        // First round of the block. The permutation input is state ^ data.
        en_cpt_perm_o  = 1'b1;
        en_reg_state_o = 1'b1;
        en_xor_data_o  = 1'b1;
        state_d        = S_RD7_10;
      end
      S_RD7_10: begin
        // If round_i never reaches 10, the FSM stays here until reset.
        en_cpt_perm_o  = 1'b1;
        en_reg_state_o = 1'b1;
        input_mode_o   = 1'b1;
        if (round_i == LAST_LOOP_RND)
          state_d = S_RD11;
      end
      S_RD11: begin
        en_reg_state_o = 1'b1;
        input_mode_o   = 1'b1;
        en_xor_lsb_o   = last_q;
        state_d        = last_q ? S_DONE : S_WAIT_AD;
      end
      S_SEP: begin
        // Empty AD: apply only the domain-separation XOR.
        en_reg_state_o = 1'b1;
        input_mode_o   = 1'b1;
        en_xor_lsb_o   = 1'b1;
        state_d        = S_DONE;
      end
      S_DONE: begin
        end_o   = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        // Any corrupted encoding falls back to IDLE with all outputs low.
        state_d = S_IDLE;
      end
    endcase
  end

  assign ad_count_o = cnt_q;

endmodule

// File: tb/tb_fsm_assoc_data.sv
// ---------------------------------------------------------------------------
// tb_fsm_assoc_data
//   Scoreboard bench for fsm_assoc_data. The driver builds each cycle's
//   expected outputs from the documented per-block timeline: a table of cycle
//   offsets after block acceptance. It queues the expected outputs for every
//   cycle in which something is asserted. A negedge monitor pops and compares
//   whenever either DUT asserts an output.
//   Two instances share the stimulus:
//     - CNT_W=8, which never saturates in this run.
//     - CNT_W=2, which saturates at 3.
// ---------------------------------------------------------------------------
module tb_fsm_assoc_data;

  logic clock_i = 1'b0;
  logic reset_i, start_i, no_ad_i, ad_valid_i, ad_last_i;
  logic [3:0] round_a = 4'd0, round_b = 4'd0;

  logic rdy_a, cpt_a, p6_a, p12_a, mode_a, reg_a, xd_a, lsb_a, end_a;
  logic rdy_b, cpt_b, p6_b, p12_b, mode_b, reg_b, xd_b, lsb_b, end_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  always #5 clock_i = ~clock_i;

  fsm_assoc_data #(.CNT_W(8)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .no_ad_i(no_ad_i),
    .ad_valid_i(ad_valid_i), .ad_last_i(ad_last_i), .round_i(round_a),
    .ad_ready_o(rdy_a), .en_cpt_perm_o(cpt_a), .init_p6_o(p6_a), .init_p12_o(p12_a),
    .input_mode_o(mode_a), .en_reg_state_o(reg_a), .en_xor_data_o(xd_a),
    .en_xor_lsb_o(lsb_a), .ad_count_o(cnt_a), .end_o(end_a));

  fsm_assoc_data #(.CNT_W(2)) dut_sat (
    .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .no_ad_i(no_ad_i),
    .ad_valid_i(ad_valid_i), .ad_last_i(ad_last_i), .round_i(round_b),
    .ad_ready_o(rdy_b), .en_cpt_perm_o(cpt_b), .init_p6_o(p6_b), .init_p12_o(p12_b),
    .input_mode_o(mode_b), .en_reg_state_o(reg_b), .en_xor_data_o(xd_b),
    .en_xor_lsb_o(lsb_b), .ad_count_o(cnt_b), .end_o(end_b));

  // Shared permutation round counter seen by each DUT.
  always @(posedge clock_i) begin
    if (p6_a) round_a <= 4'd6;
    else if (p12_a) round_a <= 4'd0;
    else if (cpt_a) round_a <= round_a + 4'd1;
    if (p6_b) round_b <= 4'd6;
    else if (p12_b) round_b <= 4'd0;
    else if (cpt_b) round_b <= round_b + 4'd1;
  end

  // Output vector layout: {ready, cpt, p6, p12, mode, reg, xor_data, xor_lsb, end}.
  localparam logic [8:0] O_READY = 9'h100;
  localparam logic [8:0] O_CONF  = 9'h0C0;
  localparam logic [8:0] O_RD6   = 9'h08C;
  localparam logic [8:0] O_LOOP  = 9'h098;
  localparam logic [8:0] O_RD11  = 9'h018;
  localparam logic [8:0] O_LSB   = 9'h002;
  localparam logic [8:0] O_SEP   = 9'h01A;
  localparam logic [8:0] O_END   = 9'h001;

  typedef struct {
    int         cyc;
    logic [8:0] outs;
    int         n;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0, errors = 0;
  int   zero_cyc = -1;
  bit   mon_en = 0, drain_chk = 0, drain_done = 0;

  always @(posedge clock_i) cyc <= cyc + 1;

  wire [8:0] obs_a = {rdy_a, cpt_a, p6_a, p12_a, mode_a, reg_a, xd_a, lsb_a, end_a};
  wire [8:0] obs_b = {rdy_b, cpt_b, p6_b, p12_b, mode_b, reg_b, xd_b, lsb_b, end_b};

  function automatic int sat(input int n, input int mx);
    return (n > mx) ? mx : n;
  endfunction

  // Expected outputs k cycles after the block is accepted.
  function automatic logic [8:0] blk_outs(input int k, input bit last);
    case (k)
      1:       return O_CONF;
      2:       return O_RD6;
      7:       return last ? (O_RD11 | O_LSB) : O_RD11;
      default: return O_LOOP;
    endcase
  endfunction

  // Monitor: event-driven comparison against the scoreboard queue.
  always @(negedge clock_i) begin
    exp_t e;
    if (cyc == zero_cyc) begin
      checks++;
      if (obs_a !== 9'h0 || obs_b !== 9'h0 || cnt_a !== 8'd0 || cnt_b !== 2'd0) begin
        errors++;
        $display("FAIL zero_state cyc=%0d outs_a=%h outs_b=%h cnt_a=%0d cnt_b=%0d expected all 0",
                 cyc, obs_a, obs_b, cnt_a, cnt_b);
      end
    end
    if (mon_en) begin
      while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        checks++; errors++;
        $display("FAIL missing_event cyc=%0d got nothing expected outs=%h n=%0d", e.cyc, e.outs, e.n);
      end
      if (obs_a != 9'h0 || obs_b != 9'h0) begin
        checks++;
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d outs_a=%h outs_b=%h expected none", cyc, obs_a, obs_b);
        end else begin
          e = exp_q.pop_front();
          if (obs_a !== e.outs || obs_b !== e.outs ||
              int'(cnt_a) != sat(e.n, 255) || int'(cnt_b) != sat(e.n, 3)) begin
            errors++;
            $display("FAIL event cyc=%0d outs_a=%h outs_b=%h cnt_a=%0d cnt_b=%0d expected outs=%h cnt_a=%0d cnt_b=%0d",
                     cyc, obs_a, obs_b, cnt_a, cnt_b, e.outs, sat(e.n, 255), sat(e.n, 3));
          end
        end
      end
      if (drain_chk && !drain_done) begin
        drain_done = 1;
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL drain leftover=%0d expected 0", exp_q.size());
        end
      end
    end
  end

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic push(input logic [8:0] outs, input int n);
    exp_q.push_back('{cyc: cyc, outs: outs, n: n});
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // One AD block. n is the count before this block.
  // abort_k != 0 asserts reset during cycle t+abort_k.
  task automatic do_block(input int n, input bit last, input bit hold,
                          input bit noise, input int abort_k);
    int d;
    d = hold ? 0 : $urandom_range(0, 2);
    repeat (d) begin
      ad_valid_i = 1'b0; ad_last_i = rbit();
      push(O_READY, n); step();
    end
    ad_valid_i = 1'b1; ad_last_i = last;
    push(O_READY, n); step();
    for (int k = 1; k <= 7; k++) begin
      ad_valid_i = hold ? 1'b1 : (noise ? rbit() : 1'b0);
      ad_last_i  = rbit();
      start_i    = noise ? rbit() : 1'b0;
      no_ad_i    = rbit();
      push(blk_outs(k, last), n);
      if (k == abort_k) reset_i = 1'b1;
      step();
      if (k == abort_k) begin
        reset_i = 1'b0; start_i = 1'b0; ad_valid_i = 1'b0;
        zero_cyc = cyc;
        step();
        return;
      end
    end
    start_i = 1'b0;
    if (!hold) ad_valid_i = 1'b0;
  endtask

  // Full AD phase. nblk == 0 means empty AD.
  task automatic run_txn(input int nblk, input bit hold, input bit noise);
    start_i = 1'b1; no_ad_i = (nblk == 0);
    ad_valid_i = noise ? rbit() : 1'b0;
    step();
    start_i = 1'b0;
    if (nblk == 0) begin
      ad_valid_i = noise ? rbit() : 1'b0;
      start_i    = noise ? rbit() : 1'b0;
      push(O_SEP, 0); step();
      start_i = 1'b0;
      push(O_END, 0); step();
    end else begin
      for (int b = 0; b < nblk; b++)
        do_block(b, (b == nblk - 1), hold, noise, 0);
      start_i = 1'b0;
      push(O_END, nblk); step();
    end
    ad_valid_i = 1'b0; start_i = 1'b0;
  endtask

  task automatic idle_gap(input int len, input bit noise);
    repeat (len) begin
      ad_valid_i = noise ? rbit() : 1'b0;
      ad_last_i  = rbit();
      step();
    end
    ad_valid_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1; start_i = 1'b0; no_ad_i = 1'b0; ad_valid_i = 1'b0; ad_last_i = 1'b0;
    step(); step();
    zero_cyc = cyc;
    reset_i = 1'b0;
    mon_en = 1;
    idle_gap(2, 0);

    run_txn(1, 0, 0);       idle_gap(2, 0);   // single last block
    run_txn(3, 1, 0);       idle_gap(2, 0);   // ad_valid held high, three blocks
    run_txn(0, 0, 0);       idle_gap(2, 0);   // empty AD

    // Reset in RD7_10 of the second block, then a clean restart.
    start_i = 1'b1; no_ad_i = 1'b0; step(); start_i = 1'b0;
    do_block(0, 0, 0, 0, 0);
    do_block(1, 1, 0, 0, 4);
    idle_gap(2, 0);
    run_txn(1, 0, 0);       idle_gap(2, 0);

    run_txn(1, 0, 1);       idle_gap(2, 1);   // ignored start/valid while busy
    run_txn(5, 0, 0);       idle_gap(2, 0);   // CNT_W=2 instance saturates

    for (int i = 0; i < 25; i++) begin
      int nb;
      nb = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 6);
      run_txn(nb, rbit(), rbit());
      idle_gap($urandom_range(0, 3), rbit());
    end

    drain_chk = 1;
    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
